// File: rtl/typing_stats_if.sv
// Signal bundle between the game FSM/keyboard side and typing_stats.
// The master drives state and keystrokes; the slave returns the round results.
interface typing_stats_if;
    logic [2:0] state;
    logic       key_valid;
    logic       key_correct;
    logic [9:0] wpm;
    logic [9:0] acc;
    logic       finish;

    modport master (
        output state, key_valid, key_correct,
        input  wpm, acc, finish
    );

    modport slave (
        input  state, key_valid, key_correct,
        output wpm, acc, finish
    );
endinterface

// File: rtl/typing_stats.sv
// Keystroke/time counters for a typing round and a shared restoring divider for WPM and accuracy.
// Define LIVE_WPM_EN to refresh wpm once per second while the round is running.
module typing_stats #(
    parameter int TICK_DIV = 10000000,
    parameter int CHAR_W   = 12,
    parameter int TIME_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    typing_stats_if.slave bus
);
    localparam int         DVW       = 20;
    localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [2:0] ST_TYPING = 3'd2;
    localparam logic [2:0] ST_RESULT = 3'd3;
    localparam logic [4:0] LAST_IT   = 5'd20;

    typedef enum logic [2:0] {IDLE, RUN, DIV_WPM, DIV_ACC, DONE} fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [2:0]          prev_state_q;
    logic [CHAR_W-1:0]   correct_q, correct_d;
    logic [CHAR_W-1:0]   total_q, total_d;
    logic [TIME_W-1:0]   tenths_q, tenths_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [9:0]          wpm_q, wpm_d;
    logic [9:0]          acc_q, acc_d;
    logic [9:0]          wpm_tmp_q, wpm_tmp_d;
    logic                finish_q, finish_d;
    logic                acc_zero_q, acc_zero_d;
    logic [4:0]          it_q, it_d;
    logic [DVW-1:0]      rem_q, rem_d;
    logic [DVW-1:0]      quo_q, quo_d;
    logic [DVW-1:0]      dvs_q, dvs_d;
    logic [DVW:0]        shift_rem;
    logic signed [DVW+1:0] trial;
    logic [DVW-1:0]      step_rem, step_quo;
    logic                entry;
`ifdef LIVE_WPM_EN
    logic [3:0]          sec_q, sec_d;
    logic                live_q, live_d;
`endif

    function automatic logic [9:0] sat_wpm(input logic [DVW-1:0] q);
        return (q > DVW'(999)) ? 10'd999 : q[9:0];
    endfunction

    function automatic logic [CHAR_W-1:0] inc_char(input logic [CHAR_W-1:0] v);
        return (&v) ? v : v + CHAR_W'(1);
    endfunction

    function automatic logic [DVW-1:0] clamp_div(input logic [TIME_W-1:0] t);
        return (t == '0) ? DVW'(1) : DVW'(t);
    endfunction

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shift_rem = {rem_q, quo_q[DVW-1]};
        trial     = $signed({1'b0, shift_rem}) - $signed({2'b00, dvs_q});
        step_rem  = (trial >= 0) ? trial[DVW-1:0] : shift_rem[DVW-1:0];
        step_quo  = {quo_q[DVW-2:0], (trial >= 0)};
    end

    always_comb begin
        fsm_d      = fsm_q;
        correct_d  = correct_q;
        total_d    = total_q;
        tenths_d   = tenths_q;
        presc_d    = presc_q;
        wpm_d      = wpm_q;
        acc_d      = acc_q;
        wpm_tmp_d  = wpm_tmp_q;
        finish_d   = finish_q;
        acc_zero_d = acc_zero_q;
        it_d       = it_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
`ifdef LIVE_WPM_EN
        sec_d      = sec_q;
        live_d     = live_q;
`endif
        entry = (bus.state != prev_state_q);

        if (entry && (bus.state == ST_TYPING)) begin
            correct_d = '0;
            total_d   = '0;
            tenths_d  = '0;
            presc_d   = '0;
            wpm_d     = '0;
            acc_d     = '0;
            finish_d  = 1'b0;
            it_d      = '0;
            fsm_d     = RUN;
`ifdef LIVE_WPM_EN
            sec_d     = '0;
            live_d    = 1'b0;
`endif
        end else begin
            unique case (fsm_q)
                RUN: begin
                    if (entry && (bus.state == ST_RESULT)) begin
                        rem_d = '0;
                        quo_d = DVW'(correct_q) * DVW'(120);
                        dvs_d = clamp_div(tenths_q);
                        it_d  = '0;
                        fsm_d = DIV_WPM;
`ifdef LIVE_WPM_EN
                        live_d = 1'b0;
`endif
                    end else begin
`ifdef LIVE_WPM_EN
                        if (live_q) begin
                            if (it_q == LAST_IT) begin
                                wpm_d  = sat_wpm(quo_q);
                                live_d = 1'b0;
                            end else begin
                                rem_d = step_rem;
                                quo_d = step_quo;
                                it_d  = it_q + 5'd1;
                            end
                        end
`endif
                        // Any other state value pauses the round with counters frozen
                        if (bus.state == ST_TYPING) begin
                            if (bus.key_valid) begin
                                total_d = inc_char(total_q);
                                if (bus.key_correct) begin
                                    correct_d = inc_char(correct_q);
                                end
                            end
                            if (presc_q == PW'(TICK_DIV - 1)) begin
                                presc_d = '0;
                                if (!(&tenths_q)) begin
                                    tenths_d = tenths_q + TIME_W'(1);
`ifdef LIVE_WPM_EN
                                    if (sec_q == 4'd9) begin
                                        sec_d  = '0;
                                        rem_d  = '0;
                                        quo_d  = DVW'(correct_q) * DVW'(120);
                                        dvs_d  = clamp_div(tenths_d);
                                        it_d   = '0;
                                        live_d = 1'b1;
                                    end else begin
                                        sec_d = sec_q + 4'd1;
                                    end
`endif
                                end
                            end else begin
                                presc_d = presc_q + PW'(1);
                            end
                        end
                    end
                end
                DIV_WPM: begin
                    if (bus.state != ST_RESULT) begin
                        fsm_d = IDLE;
                    end else if (it_q == LAST_IT) begin
                        wpm_tmp_d  = sat_wpm(quo_q);
                        acc_zero_d = (total_q == '0);
                        rem_d      = '0;
                        quo_d      = DVW'(correct_q) * DVW'(100);
                        dvs_d      = DVW'(total_q);
                        it_d       = '0;
                        fsm_d      = DIV_ACC;
                    end else begin
                        rem_d = step_rem;
                        quo_d = step_quo;
                        it_d  = it_q + 5'd1;
                    end
                end
                DIV_ACC: begin
                    if (bus.state != ST_RESULT) begin
                        fsm_d = IDLE;
                    end else if (it_q == LAST_IT) begin
                        // A zero divisor would yield all-ones, so no keys reads as 0 %
                        wpm_d    = wpm_tmp_q;
                        acc_d    = acc_zero_q ? 10'd0 : quo_q[9:0];
                        finish_d = 1'b1;
                        fsm_d    = DONE;
                    end else begin
                        rem_d = step_rem;
                        quo_d = step_quo;
                        it_d  = it_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= IDLE;
            prev_state_q <= '0;
            correct_q    <= '0;
            total_q      <= '0;
            tenths_q     <= '0;
            presc_q      <= '0;
            wpm_q        <= '0;
            acc_q        <= '0;
            wpm_tmp_q    <= '0;
            finish_q     <= 1'b0;
            acc_zero_q   <= 1'b0;
            it_q         <= '0;
`ifdef LIVE_WPM_EN
            sec_q        <= '0;
            live_q       <= 1'b0;
`endif
        end else begin
            fsm_q        <= fsm_d;
            prev_state_q <= bus.state;
            correct_q    <= correct_d;
            total_q      <= total_d;
            tenths_q     <= tenths_d;
            presc_q      <= presc_d;
            wpm_q        <= wpm_d;
            acc_q        <= acc_d;
            wpm_tmp_q    <= wpm_tmp_d;
            finish_q     <= finish_d;
            acc_zero_q   <= acc_zero_d;
            it_q         <= it_d;
`ifdef LIVE_WPM_EN
            sec_q        <= sec_d;
            live_q       <= live_d;
`endif
        end
    end

    // Divider datapath is always loaded before use, so it carries no reset
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

    assign bus.wpm    = wpm_q;
    assign bus.acc    = acc_q;
    assign bus.finish = finish_q;
endmodule

// File: tb/tb_typing_stats.sv
// Directed self-checking bench for typing_stats with TICK_DIV=10 (10 clocks per tenth).
// Expected values are hand-computed from key counts and elapsed tenths.
module tb_typing_stats;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    typing_stats_if bus();

    typing_stats #(
        .TICK_DIV(10),
        .CHAR_W  (12),
        .TIME_W  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_keys(input int n, input int nvalid, input int ncorrect);
        for (int i = 0; i < n; i++) begin
            bus.key_valid   = (i < nvalid);
            bus.key_correct = (i < ncorrect);
            tick();
        end
        bus.key_valid   = 1'b0;
        bus.key_correct = 1'b0;
    endtask

    task automatic start_round(input logic entry_key);
        bus.state       = 3'd2;
        bus.key_valid   = entry_key;
        bus.key_correct = entry_key;
        tick();
        bus.key_valid   = 1'b0;
        bus.key_correct = 1'b0;
    endtask

    task automatic finish_round(input string tag, input logic kv, input logic kc,
                                input int exp_wpm, input int exp_acc);
        bus.state       = 3'd3;
        bus.key_valid   = kv;
        bus.key_correct = kc;
        tick();
        bus.key_valid   = 1'b0;
        bus.key_correct = 1'b0;
        tick(41);
        check({tag, "_finish_e41"}, 32'(bus.finish), 32'd0);
        tick();
        check({tag, "_finish_e42"}, 32'(bus.finish), 32'd1);
        check({tag, "_wpm"}, 32'(bus.wpm), 32'(exp_wpm));
        check({tag, "_acc"}, 32'(bus.acc), 32'(exp_acc));
    endtask

    initial begin
        bus.state       = 3'd0;
        bus.key_valid   = 1'b0;
        bus.key_correct = 1'b0;
        rst             = 1'b1;
        tick(3);
        check("reset_wpm", 32'(bus.wpm), 32'd0);
        check("reset_acc", 32'(bus.acc), 32'd0);
        check("reset_finish", 32'(bus.finish), 32'd0);
        rst = 1'b0;
        tick(2);

        // 50 correct keys over 600 tenths: 6000/600 = 10 wpm, 100 %
        start_round(1'b0);
        run_keys(6000, 50, 50);
`ifndef LIVE_WPM_EN
        check("r1_run_wpm", 32'(bus.wpm), 32'd0);
`endif
        finish_round("r1", 1'b0, 1'b0, 10, 100);

        // 45 of 60 correct over 300 tenths: 5400/300 = 18 wpm, 75 %
        start_round(1'b0);
        run_keys(3000, 60, 45);
        finish_round("r2", 1'b0, 1'b0, 18, 75);

        // Re-entering RESULT from DONE must not recompute or disturb results
        bus.state = 3'd1;
        tick(5);
        bus.state = 3'd3;
        tick(60);
        check("hold_wpm", 32'(bus.wpm), 32'd18);
        check("hold_acc", 32'(bus.acc), 32'd75);
        check("hold_finish", 32'(bus.finish), 32'd1);

        // tenths=0 clamps divisor to 1; entry-cycle and RESULT-cycle keys are dropped
        start_round(1'b1);
        run_keys(5, 3, 3);
        finish_round("clamp", 1'b1, 1'b0, 360, 100);

        start_round(1'b0);
        run_keys(30, 0, 0);
        finish_round("nokeys", 1'b0, 1'b0, 0, 0);

        // 4300 keys saturate both counters at 4095; 491400/430 exceeds 999
        start_round(1'b0);
        run_keys(4300, 4300, 4300);
        finish_round("sat", 1'b0, 1'b0, 999, 100);

        // Leaving RESULT at E0+10 aborts the computation
        start_round(1'b0);
        run_keys(20, 10, 10);
        bus.state = 3'd3;
        tick();
        tick(9);
        bus.state = 3'd1;
        tick(50);
        check("abort_finish", 32'(bus.finish), 32'd0);
        check("abort_wpm", 32'(bus.wpm), 32'd0);
        check("abort_acc", 32'(bus.acc), 32'd0);

`ifdef LIVE_WPM_EN
        // 20 correct keys in the first second: 2400/10 = 240 wpm after 21 cycles
        start_round(1'b0);
        run_keys(100, 20, 20);
        tick(20);
        check("live_wpm_e20", 32'(bus.wpm), 32'd0);
        tick();
        check("live_wpm_e21", 32'(bus.wpm), 32'd240);
        check("live_finish", 32'(bus.finish), 32'd0);
`endif

        // rst at E0+30 clears everything; held RESULT afterwards does not start a division
        start_round(1'b0);
        run_keys(20, 10, 10);
        bus.state = 3'd3;
        tick();
        tick(29);
        rst = 1'b1;
        tick();
        check("rst_wpm", 32'(bus.wpm), 32'd0);
        check("rst_acc", 32'(bus.acc), 32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);
        rst = 1'b0;
        tick(60);
        check("post_rst_finish", 32'(bus.finish), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
